// File: rtl/cpu_pkg.sv
// Shared types and constants for the operand-fetch slice of the CPU pipeline.
// XLEN      : operand/data width
// NREGS     : architectural register count
// REG_IDX_W : register index width
// PAYLOAD_W : width of the opaque decoded control carried to execute
// reg_idx_t   : register index type
// of_bundle_t : contents of the operand-fetch output register
package cpu_pkg;

    localparam int XLEN      = 32;
    localparam int NREGS     = 32;
    localparam int REG_IDX_W = $clog2(NREGS);
    localparam int PAYLOAD_W = 96;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef struct packed {
        logic [XLEN-1:0]      a;
        logic [XLEN-1:0]      b;
        reg_idx_t             rd;
        logic                 rd_we;
        logic [PAYLOAD_W-1:0] payload;
    } of_bundle_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set when a
// writer issues and cleared when it retires or is flushed out of the stage.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   set_en/set_idx      : mark a register as having an in-flight writer
//   clr_en/clr_idx      : writeback retirement (written or killed)
//   fclr_en/fclr_idx    : flush of the writer held in the output register
//   raw1_idx, raw2_idx  : source registers to test for RAW hazards
//   waw_en/waw_idx      : destination register to test for WAW hazard
//   raw1, raw2, waw     : hazard results (retiring register is exempt)
//   pend                : current scoreboard contents
module reg_scoreboard
    import cpu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             set_en,
    input  reg_idx_t         set_idx,
    input  logic             clr_en,
    input  reg_idx_t         clr_idx,
    input  logic             fclr_en,
    input  reg_idx_t         fclr_idx,
    input  reg_idx_t         raw1_idx,
    input  reg_idx_t         raw2_idx,
    input  logic             waw_en,
    input  reg_idx_t         waw_idx,
    output logic             raw1,
    output logic             raw2,
    output logic             waw,
    output logic [NREGS-1:0] pend
);

    logic [NREGS-1:0] pend_reg;
    logic [NREGS-1:0] pend_next;

    // x0 is hardwired to zero and never tracked.
    assign pend_next[0] = 1'b0;

    // Set has priority over both clears: the only legal overlap is a new
    // writer issuing in the same cycle its predecessor retires.
    genvar gi;
    generate
        for (gi = 1; gi < NREGS; gi++) begin : g_pend
            localparam reg_idx_t IDX = reg_idx_t'(gi);
            assign pend_next[gi] = (set_en && set_idx == IDX) ||
                                   (pend_reg[gi] &&
                                    !(clr_en && clr_idx == IDX) &&
                                    !(fclr_en && fclr_idx == IDX));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_reg <= '0;
        end else begin
            pend_reg <= pend_next;
        end
    end

    // A register retiring this cycle no longer blocks: its value is on the
    // bypass (or it was killed and the register file already holds the
    // architectural value).
    assign raw1 = (raw1_idx != '0) && pend_reg[raw1_idx] &&
                  !(clr_en && clr_idx == raw1_idx);
    assign raw2 = (raw2_idx != '0) && pend_reg[raw2_idx] &&
                  !(clr_en && clr_idx == raw2_idx);
    assign waw  = waw_en && (waw_idx != '0) && pend_reg[waw_idx] &&
                  !(clr_en && clr_idx == waw_idx);

    assign pend = pend_reg;

endmodule

// File: rtl/operand_fetch_stage.sv
// Decode-to-execute operand fetch stage. Drives register-file read addresses,
// merges read data with the writeback bypass, stalls on RAW/WAW hazards
// tracked by a scoreboard and holds the result in a valid/ready register.
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   id_valid/id_ready           : decode handshake
//   id_rs1, id_rs2, id_rd,
//   id_rd_we, id_payload        : decoded instruction
//   rf_ra, rf_rb / rf_a, rf_b   : register-file read addresses / data
//   wb_valid, wb_wen, wb_rd,
//   wb_data                     : retirement from writeback
//   flush                       : kill held and offered instructions
//   ex_valid/ex_ready           : execute handshake
//   ex_a, ex_b, ex_rd,
//   ex_rd_we, ex_payload        : registered operands and control
// The bundle type comes from cpu_pkg, so the parameters are expected to
// keep their package-derived defaults.
module operand_fetch_stage
    import cpu_pkg::*;
#(
    parameter int XLEN      = cpu_pkg::XLEN,
    parameter int NREGS     = cpu_pkg::NREGS,
    parameter int PAYLOAD_W = cpu_pkg::PAYLOAD_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 id_valid,
    output logic                 id_ready,
    input  reg_idx_t             id_rs1,
    input  reg_idx_t             id_rs2,
    input  reg_idx_t             id_rd,
    input  logic                 id_rd_we,
    input  logic [PAYLOAD_W-1:0] id_payload,
    output reg_idx_t             rf_ra,
    output reg_idx_t             rf_rb,
    input  logic [XLEN-1:0]      rf_a,
    input  logic [XLEN-1:0]      rf_b,
    input  logic                 wb_valid,
    input  logic                 wb_wen,
    input  reg_idx_t             wb_rd,
    input  logic [XLEN-1:0]      wb_data,
    input  logic                 flush,
    output logic                 ex_valid,
    input  logic                 ex_ready,
    output logic [XLEN-1:0]      ex_a,
    output logic [XLEN-1:0]      ex_b,
    output reg_idx_t             ex_rd,
    output logic                 ex_rd_we,
    output logic [PAYLOAD_W-1:0] ex_payload
);

    logic             ex_valid_reg;
    of_bundle_t       ex_bundle_reg;
    of_bundle_t       ex_bundle_next;
    logic [XLEN-1:0]  op1;
    logic [XLEN-1:0]  op2;
    logic             raw1;
    logic             raw2;
    logic             waw;
    logic             space;
    logic             issue;
    logic             set_en;
    logic             fclr_en;
    logic [NREGS-1:0] pend;

    assign rf_ra = id_rs1;
    assign rf_rb = id_rs2;

    // The register file commits at the edge, so a same-cycle writeback must
    // be forwarded here or the stage would capture the stale value.
    assign op1 = (wb_valid && wb_wen && wb_rd == id_rs1 && id_rs1 != '0) ? wb_data : rf_a;
    assign op2 = (wb_valid && wb_wen && wb_rd == id_rs2 && id_rs2 != '0) ? wb_data : rf_b;

    assign space    = !ex_valid_reg || ex_ready;
    assign id_ready = space && !raw1 && !raw2 && !waw && !flush;
    assign issue    = id_valid && id_ready;
    assign set_en   = issue && id_rd_we && (id_rd != '0);
    // The held writer is discarded and will never retire, so its pending
    // bit has to be dropped here.
    assign fclr_en  = flush && ex_valid_reg && ex_bundle_reg.rd_we && (ex_bundle_reg.rd != '0);

    reg_scoreboard u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .set_en   (set_en),
        .set_idx  (id_rd),
        .clr_en   (wb_valid),
        .clr_idx  (wb_rd),
        .fclr_en  (fclr_en),
        .fclr_idx (ex_bundle_reg.rd),
        .raw1_idx (id_rs1),
        .raw2_idx (id_rs2),
        .waw_en   (id_rd_we),
        .waw_idx  (id_rd),
        .raw1     (raw1),
        .raw2     (raw2),
        .waw      (waw),
        .pend     (pend)
    );

    always_comb begin
        ex_bundle_next         = ex_bundle_reg;
        ex_bundle_next.a       = op1;
        ex_bundle_next.b       = op2;
        ex_bundle_next.rd      = id_rd;
        ex_bundle_next.rd_we   = id_rd_we;
        ex_bundle_next.payload = id_payload;
    end

    // Data fields only change on issue; drain and flush just drop valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_reg  <= 1'b0;
            ex_bundle_reg <= '0;
        end else if (flush) begin
            ex_valid_reg  <= 1'b0;
        end else if (issue) begin
            ex_valid_reg  <= 1'b1;
            ex_bundle_reg <= ex_bundle_next;
        end else if (ex_ready) begin
            ex_valid_reg  <= 1'b0;
        end
    end

    assign ex_valid   = ex_valid_reg;
    assign ex_a       = ex_bundle_reg.a;
    assign ex_b       = ex_bundle_reg.b;
    assign ex_rd      = ex_bundle_reg.rd;
    assign ex_rd_we   = ex_bundle_reg.rd_we;
    assign ex_payload = ex_bundle_reg.payload;

    // Every retirement must correspond to a tracked in-flight writer.
    a_wb_pending: assert property (@(posedge clk) disable iff (reset)
        (wb_valid && wb_rd != '0) |-> pend[wb_rd]);

    // Back-pressured output must not change under the consumer.
    a_ex_stable: assert property (@(posedge clk)
        (!reset && !flush && ex_valid_reg && !ex_ready) |=>
        (ex_valid_reg && $stable(ex_bundle_reg)));

endmodule

// File: tb/tb_operand_fetch_stage.sv
module tb_operand_fetch_stage;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic        id_ready;
    reg_idx_t    id_rs1, id_rs2, id_rd;
    logic        id_rd_we;
    logic [95:0] id_payload;
    reg_idx_t    rf_ra, rf_rb;
    logic [31:0] rf_a, rf_b;
    logic        wb_valid, wb_wen;
    reg_idx_t    wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        ex_valid, ex_ready;
    logic [31:0] ex_a, ex_b;
    reg_idx_t    ex_rd;
    logic        ex_rd_we;
    logic [95:0] ex_payload;

    // Register file environment (preload path used to seed known values)
    logic        pre_en;
    reg_idx_t    pre_idx;
    logic [31:0] pre_data;
    logic [31:0] rf_mem [32];

    int checks = 0;
    int errors = 0;

    // Reference model state: pending-writer set and expected output register
    bit [31:0]   pend_m;
    bit          exv_m;
    logic [31:0] exa_m, exb_m;
    reg_idx_t    exrd_m;
    logic        exwe_m;
    logic [95:0] expl_m;
    bit          exp_ready;
    logic        obs_ready;

    always #5 clk = ~clk;

    assign rf_a = (rf_ra == 5'd0) ? 32'd0 : rf_mem[rf_ra];
    assign rf_b = (rf_rb == 5'd0) ? 32'd0 : rf_mem[rf_rb];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= 32'h0101_0101 * i;
        end else begin
            if (pre_en) rf_mem[pre_idx] <= pre_data;
            if (wb_valid && wb_wen && wb_rd != 5'd0) rf_mem[wb_rd] <= wb_data;
        end
    end

    operand_fetch_stage dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rd_we(id_rd_we), .id_payload(id_payload),
        .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_a(rf_a), .rf_b(rf_b),
        .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_a(ex_a), .ex_b(ex_b), .ex_rd(ex_rd), .ex_rd_we(ex_rd_we),
        .ex_payload(ex_payload)
    );

    function automatic logic [95:0] rnd_payload();
        return {$urandom, $urandom, $urandom};
    endfunction

    // Operand value the instruction should see: newest architectural value.
    function automatic logic [31:0] operand(reg_idx_t rs);
        if (rs == 5'd0) return 32'd0;
        if (wb_valid && wb_wen && wb_rd == rs) return wb_data;
        return rf_mem[rs];
    endfunction

    function automatic bit model_ready();
        bit r1, r2, w;
        r1 = id_rs1 != 0 && pend_m[id_rs1] && !(wb_valid && wb_rd == id_rs1);
        r2 = id_rs2 != 0 && pend_m[id_rs2] && !(wb_valid && wb_rd == id_rs2);
        w  = id_rd_we && id_rd != 0 && pend_m[id_rd] && !(wb_valid && wb_rd == id_rd);
        return (!exv_m || ex_ready) && !r1 && !r2 && !w && !flush;
    endfunction

    task automatic idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_rd_we = 0;
        id_payload = '0; wb_valid = 0; wb_wen = 0; wb_rd = 0; wb_data = 0;
        flush = 0; ex_ready = 1; pre_en = 0; pre_idx = 0; pre_data = 0;
    endtask

    // One clock: snapshot id_ready, advance the reference model, settle.
    task automatic tick();
        bit          iss;
        logic [31:0] o1, o2;
        #1;
        exp_ready = model_ready();
        obs_ready = id_ready;
        iss = id_valid && exp_ready;
        o1 = operand(id_rs1);
        o2 = operand(id_rs2);
        @(posedge clk);
        if (reset) begin
            pend_m = '0; exv_m = 0; exa_m = '0; exb_m = '0;
            exrd_m = '0; exwe_m = 0; expl_m = '0;
        end else begin
            if (wb_valid) pend_m[wb_rd] = 1'b0;
            if (flush && exv_m && exwe_m && exrd_m != 0) pend_m[exrd_m] = 1'b0;
            if (iss && id_rd_we && id_rd != 0) pend_m[id_rd] = 1'b1;
            if (flush) exv_m = 0;
            else if (iss) begin
                exv_m = 1; exa_m = o1; exb_m = o2;
                exrd_m = id_rd; exwe_m = id_rd_we; expl_m = id_payload;
            end else if (ex_ready) exv_m = 0;
        end
        #1;
    endtask

    task automatic preload(input reg_idx_t idx, input logic [31:0] data);
        idle();
        pre_en = 1; pre_idx = idx; pre_data = data;
        tick();
        pre_en = 0;
    endtask

    task automatic issue_writer(input reg_idx_t rd, input logic [95:0] p);
        idle();
        id_valid = 1; id_rd = rd; id_rd_we = 1; id_payload = p;
        tick();
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        tick(); tick();
        reset = 0;
        checks++;
        if (ex_valid !== 1'b0 || ex_a !== 32'd0 || ex_b !== 32'd0 || ex_rd !== 5'd0 ||
            ex_rd_we !== 1'b0 || ex_payload !== 96'd0) begin
            errors++;
            $display("FAIL reset_outputs valid=%b a=%h b=%h rd=%0d we=%b pl=%h want all zero",
                     ex_valid, ex_a, ex_b, ex_rd, ex_rd_we, ex_payload);
        end
        id_rs1 = 13; id_rs2 = 22;
        #1;
        checks++;
        if (rf_ra !== 5'd13 || rf_rb !== 5'd22) begin
            errors++;
            $display("FAIL rf_addr got ra=%0d rb=%0d want 13 22", rf_ra, rf_rb);
        end
        tick();
        checks++;
        if (obs_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b want 1", obs_ready);
        end
    endtask

    task automatic test_basic();
        logic [95:0] p;
        preload(3, 32'h11);
        p = rnd_payload();
        idle();
        id_valid = 1; id_rs1 = 3; id_rs2 = 0; id_rd = 3; id_rd_we = 0; id_payload = p;
        tick();
        checks++;
        if (obs_ready !== 1'b1 || ex_valid !== 1'b1 || ex_a !== 32'h11 || ex_b !== 32'd0 ||
            ex_rd_we !== 1'b0 || ex_payload !== p) begin
            errors++;
            $display("FAIL basic_issue rdy=%b v=%b a=%h b=%h we=%b pl=%h want 1 1 11 0 0 %h",
                     obs_ready, ex_valid, ex_a, ex_b, ex_rd_we, ex_payload, p);
        end
        id_rs2 = 3; id_payload = rnd_payload();
        tick();
        checks++;
        if (obs_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_no_pend got ready=%b want 1", obs_ready);
        end
        idle(); tick();
    endtask

    task automatic test_bypass();
        preload(5, 32'h55);
        issue_writer(5, rnd_payload());
        id_valid = 1; id_rs1 = 5; id_rd = 0; id_rd_we = 0; id_payload = rnd_payload();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs_ready !== 1'b0) begin
                errors++;
                $display("FAIL raw_stall cycle %0d got ready=%b want 0", i, obs_ready);
            end
        end
        wb_valid = 1; wb_wen = 1; wb_rd = 5; wb_data = 32'hDEAD;
        tick();
        checks++;
        if (obs_ready !== 1'b1 || ex_valid !== 1'b1 || ex_a !== 32'hDEAD) begin
            errors++;
            $display("FAIL bypass rdy=%b v=%b a=%h want 1 1 0000dead", obs_ready, ex_valid, ex_a);
        end
        wb_valid = 0; wb_wen = 0;
        tick();
        checks++;
        if (ex_a !== 32'hDEAD) begin
            errors++;
            $display("FAIL rf_after_wb got a=%h want 0000dead", ex_a);
        end
        idle(); tick();
    endtask

    task automatic test_stall();
        logic [95:0] pa, pb;
        pa = rnd_payload(); pb = rnd_payload();
        idle();
        id_valid = 1; id_rs1 = 3; id_payload = pa;
        tick();
        ex_ready = 0; id_rs1 = 5; id_payload = pb;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (obs_ready !== 1'b0 || ex_valid !== 1'b1 || ex_a !== 32'h11 || ex_payload !== pa) begin
                errors++;
                $display("FAIL stall_hold cycle %0d rdy=%b v=%b a=%h pl=%h want 0 1 11 %h",
                         i, obs_ready, ex_valid, ex_a, ex_payload, pa);
            end
        end
        ex_ready = 1;
        tick();
        checks++;
        if (obs_ready !== 1'b1 || ex_valid !== 1'b1 || ex_a !== 32'hDEAD || ex_payload !== pb) begin
            errors++;
            $display("FAIL stall_release rdy=%b v=%b a=%h pl=%h want 1 1 dead %h",
                     obs_ready, ex_valid, ex_a, ex_payload, pb);
        end
        idle(); tick();
    endtask

    task automatic test_waw();
        logic [95:0] p2;
        preload(2, 32'h22);
        issue_writer(7, rnd_payload());
        p2 = rnd_payload();
        id_valid = 1; id_rd = 7; id_rd_we = 1; id_rs1 = 2; id_rs2 = 0; id_payload = p2;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (obs_ready !== 1'b0) begin
                errors++;
                $display("FAIL waw_stall cycle %0d got ready=%b want 0", i, obs_ready);
            end
        end
        wb_valid = 1; wb_wen = 0; wb_rd = 7; wb_data = $urandom;
        tick();
        checks++;
        if (obs_ready !== 1'b1 || ex_rd !== 5'd7 || ex_rd_we !== 1'b1 || ex_a !== 32'h22 ||
            ex_payload !== p2) begin
            errors++;
            $display("FAIL waw_release rdy=%b rd=%0d we=%b a=%h want 1 7 1 22",
                     obs_ready, ex_rd, ex_rd_we, ex_a);
        end
        idle();
        id_valid = 1; id_rs1 = 7;
        tick();
        checks++;
        if (obs_ready !== 1'b0) begin
            errors++;
            $display("FAIL waw_pend_set got ready=%b want 0", obs_ready);
        end
        wb_valid = 1; wb_wen = 1; wb_rd = 7; wb_data = 32'h77;
        tick();
        checks++;
        if (obs_ready !== 1'b1 || ex_a !== 32'h77) begin
            errors++;
            $display("FAIL waw_retire rdy=%b a=%h want 1 77", obs_ready, ex_a);
        end
        idle(); tick();
    endtask

    task automatic test_flush();
        logic [95:0] p9, pr;
        p9 = rnd_payload(); pr = rnd_payload();
        issue_writer(9, p9);
        ex_ready = 0; id_rd = 0; id_rd_we = 0; id_payload = rnd_payload(); flush = 1;
        tick();
        checks++;
        if (obs_ready !== 1'b0 || ex_valid !== 1'b0 || ex_payload !== p9) begin
            errors++;
            $display("FAIL flush rdy=%b v=%b pl=%h want 0 0 %h", obs_ready, ex_valid, ex_payload, p9);
        end
        flush = 0; ex_ready = 1; id_rs1 = 9; id_payload = pr;
        tick();
        checks++;
        if (obs_ready !== 1'b1 || ex_valid !== 1'b1 || ex_payload !== pr) begin
            errors++;
            $display("FAIL flush_pend_clear rdy=%b v=%b want 1 1", obs_ready, ex_valid);
        end
        idle(); tick();
    endtask

    task automatic test_reset_mid();
        issue_writer(4, rnd_payload());
        issue_writer(6, rnd_payload());
        ex_ready = 0; id_rd = 0; id_rd_we = 0; id_rs1 = 4;
        tick();
        checks++;
        if (obs_ready !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset_stall got ready=%b want 0", obs_ready);
        end
        reset = 1;
        tick();
        reset = 0;
        checks++;
        if (ex_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_valid got %b want 0", ex_valid);
        end
        ex_ready = 1; id_rs1 = 4; id_rs2 = 6; id_rd = 4; id_rd_we = 1;
        tick();
        checks++;
        if (obs_ready !== 1'b1 || ex_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_clear rdy=%b v=%b want 1 1", obs_ready, ex_valid);
        end
        idle();
        wb_valid = 1; wb_wen = 1; wb_rd = 4; wb_data = $urandom;
        tick();
        idle(); tick();
    endtask

    task automatic test_back_to_back();
        logic [95:0] p;
        idle();
        for (int i = 0; i < 5; i++) begin
            p = rnd_payload();
            id_valid = 1; id_rs1 = reg_idx_t'(i + 1); id_payload = p;
            tick();
            checks++;
            if (obs_ready !== 1'b1 || ex_valid !== 1'b1 || ex_payload !== p) begin
                errors++;
                $display("FAIL back_to_back %0d rdy=%b v=%b pl=%h want 1 1 %h",
                         i, obs_ready, ex_valid, ex_payload, p);
            end
        end
        idle(); tick();
    endtask

    task automatic test_random();
        int npend, pick;
        for (int c = 0; c < 500; c++) begin
            idle();
            id_valid   = ($urandom_range(0, 9) < 7);
            id_rs1     = reg_idx_t'($urandom_range(0, 7));
            id_rs2     = reg_idx_t'($urandom_range(0, 7));
            id_rd      = reg_idx_t'($urandom_range(0, 7));
            id_rd_we   = $urandom_range(0, 1) == 1;
            id_payload = rnd_payload();
            ex_ready   = ($urandom_range(0, 9) < 7);
            flush      = ($urandom_range(0, 19) == 0);
            npend = 0;
            for (int r = 1; r < 32; r++) if (pend_m[r]) npend++;
            if (npend > 0 && $urandom_range(0, 9) < 4) begin
                pick = $urandom_range(0, npend - 1);
                for (int r = 1; r < 32; r++) begin
                    if (pend_m[r]) begin
                        if (pick == 0) wb_rd = reg_idx_t'(r);
                        pick--;
                    end
                end
                wb_valid = 1; wb_wen = $urandom_range(0, 1) == 1; wb_data = $urandom;
            end
            tick();
            checks++;
            if (obs_ready !== exp_ready) begin
                errors++;
                $display("FAIL rand_ready cycle %0d got %b want %b", c, obs_ready, exp_ready);
            end
            checks++;
            if (ex_valid !== exv_m || ex_a !== exa_m || ex_b !== exb_m || ex_rd !== exrd_m ||
                ex_rd_we !== exwe_m || ex_payload !== expl_m) begin
                errors++;
                $display("FAIL rand_ex cycle %0d got v=%b a=%h b=%h rd=%0d we=%b want v=%b a=%h b=%h rd=%0d we=%b",
                         c, ex_valid, ex_a, ex_b, ex_rd, ex_rd_we, exv_m, exa_m, exb_m, exrd_m, exwe_m);
            end
        end
        idle(); tick();
    endtask

    initial begin
        reset = 1;
        idle();
        pend_m = '0; exv_m = 0; exa_m = '0; exb_m = '0; exrd_m = '0; exwe_m = 0; expl_m = '0;
        test_reset();
        test_basic();
        test_bypass();
        test_stall();
        test_waw();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
